ddr_ctrl_arbit: RTL and testbench
=================================

Name: ddr_ctrl_arbit

Overview:
- Command arbiter between the SDRAM init, auto-refresh, write and read sub-controllers; drives the single SDRAM command/address/data bus.
- Sits directly upstream of ddr_ctrl_rd: grants it with a one-cycle rd_en pulse, then forwards its cmd/ba/addr to the pins until its end pulse.
- Same for the write and auto-refresh engines. Fixed priority: aref > write > read. No preemption.

Parameters:
- ADDR_W, 13, SDRAM row/column address width
- BA_W, 2, bank address width
- DATA_W, 16, SDRAM data width
- CMD_W, 4, command width, encoded {cs_n, ras_n, cas_n, we_n}

Ports:
- sys_clk  in  1  system clock; all state on rising edge
- sys_rst_n  in  1  asynchronous, active-low reset
- init_end_i  in  1  init sequence complete; level, stays high
- init_bus_i  in  CMD_W+BA_W+ADDR_W  init engine {cmd,ba,addr}
- aref_req_i  in  1  refresh request; level, held until granted
- aref_end_i  in  1  refresh done; one-cycle pulse
- aref_bus_i  in  CMD_W+BA_W+ADDR_W  refresh engine {cmd,ba,addr}
- wr_req_i  in  1  write request; level, held until granted
- wr_end_i  in  1  write done; one-cycle pulse
- wr_bus_i  in  CMD_W+BA_W+ADDR_W  write engine {cmd,ba,addr}
- wr_data_i  in  DATA_W  write data from write engine
- wr_sdram_en_i  in  1  write engine data-drive enable
- rd_req_i  in  1  read request; level, held until granted
- rd_end_i  in  1  read done; one-cycle pulse (rd_end_o of ddr_ctrl_rd)
- rd_bus_i  in  CMD_W+BA_W+ADDR_W  read engine {cmd,ba,addr}
- aref_en_o  out  1  refresh grant; one-cycle pulse
- wr_en_o  out  1  write grant; one-cycle pulse
- rd_en_o  out  1  read grant; one-cycle pulse (drives rd_en_i of ddr_ctrl_rd)
- sdram_cmd_o  out  CMD_W  command to pins
- sdram_ba_o  out  BA_W  bank to pins
- sdram_addr_o  out  ADDR_W  address to pins
- sdram_dq_o  out  DATA_W  data to pins
- sdram_dq_oe_o  out  1  dq output enable

Behaviour:
- Reset (async, sys_rst_n=0):
  - State returns to IDLE immediately, including mid-transaction.
  - All en_o = 0; sdram_dq_oe_o = 0; sdram_dq_o = 0.
  - Muxed bus follows init_bus_i, as in IDLE.
- States and transitions:
  - IDLE → ARBIT when init_end_i = 1.
  - ARBIT → AREF / WRITE / READ by priority aref_req_i > wr_req_i > rd_req_i; stays in ARBIT if no request.
  - AREF → ARBIT on aref_end_i; WRITE → ARBIT on wr_end_i; READ → ARBIT on rd_end_i.
  - An end pulse arriving in any other state is ignored.
- Grant latency: a request sampled in ARBIT at edge k gives the new state and its en_o = 1 during cycle k+1, for exactly one cycle.
- en_o outputs are registered and mutually exclusive.
- No back-to-back grants: at least one ARBIT cycle between transactions. A request asserted in the same cycle as an end pulse is granted at the next-but-one edge.
- A request raised during another transaction waits; there is no preemption.
- Simultaneous requests: highest priority wins; losers remain pending.
- Bus mux (combinational from state):
  - IDLE → init_bus_i
  - AREF → aref_bus_i
  - WRITE → wr_bus_i
  - READ → rd_bus_i
  - ARBIT → cmd NOP 4'b0111, ba all-ones, addr all-ones
- Data path:
  - sdram_dq_o = wr_data_i.
  - sdram_dq_oe_o = wr_sdram_en_i only in WRITE, else 0.
  - The read data return path bypasses this block.
- init_end_i falling after init is ignored; there is no return to IDLE except via reset.

Decomposition:
- Package sdram_ctrl_pkg:
  - CMD_W/BA_W/ADDR_W/DATA_W
  - Command constants NOP 4'b0111, PRECHARGE 4'b0010, AREF 4'b0001, ACTIVE 4'b0011, READ 4'b0101, WRITE 4'b0100
  - Packed struct sdram_bus_t {cmd, ba, addr}
  - Enum arb_state_t {IDLE, ARBIT, AREF, WRITE, READ}
- Shared with ddr_ctrl_rd and the write engine.
- No sub-module; the FSM and mux stay in one file.

Test Plan:
- Reset then init_end_i=1 at cycle 3 → state ARBIT at cycle 4; sdram_cmd_o=4'b0111, ba=2'b11, addr=13'h1FFF.
- rd_req_i=1 in ARBIT → rd_en_o=1 for one cycle. While READ, rd_bus_i={4'b0101,2'b01,13'h0123} appears unchanged on the pins. rd_end_i pulse → next cycle cmd=NOP.
- aref_req_i, wr_req_i and rd_req_i all raised in the same cycle → order AREF, WRITE, READ. Each grant pulse is one cycle, with ≥1 ARBIT cycle between them.
- aref_req_i raised mid-READ → no aref_en_o until rd_end_i; aref_en_o rises 2 cycles after the rd_end_i pulse.
- WRITE with wr_sdram_en_i=1 and wr_data_i=16'hA5A5 → sdram_dq_oe_o=1 and dq=16'hA5A5. In READ with wr_sdram_en_i=1 → sdram_dq_oe_o=0.
- sys_rst_n=0 asynchronously mid-WRITE → same timestep: dq_oe=0, en_o all 0, state IDLE. After release, no grants until init_end_i is observed high.

Source files
------------

// File: rtl/sdram_ctrl_pkg.sv
// Shared SDRAM controller types: bus widths, command encodings, pin bus struct
// and the arbiter state encoding used by ddr_ctrl_arbit and its engines.
package sdram_ctrl_pkg;

  localparam int CMD_W  = 4;
  localparam int BA_W   = 2;
  localparam int ADDR_W = 13;
  localparam int DATA_W = 16;

  // {cs_n, ras_n, cas_n, we_n}
  localparam logic [3:0] CMD_NOP       = 4'b0111;
  localparam logic [3:0] CMD_PRECHARGE = 4'b0010;
  localparam logic [3:0] CMD_AREF      = 4'b0001;
  localparam logic [3:0] CMD_ACTIVE    = 4'b0011;
  localparam logic [3:0] CMD_READ      = 4'b0101;
  localparam logic [3:0] CMD_WRITE     = 4'b0100;

  typedef struct packed {
    logic [CMD_W-1:0]  cmd;
    logic [BA_W-1:0]   ba;
    logic [ADDR_W-1:0] addr;
  } sdram_bus_t;

  typedef enum logic [2:0] {
    IDLE,
    ARBIT,
    AREF,
    WRITE,
    READ
  } arb_state_t;

endpackage

// File: rtl/ddr_ctrl_arbit.sv
// SDRAM command arbiter: fixed priority aref > write > read, no preemption,
// one-cycle grant pulses and a state-selected command/address/data mux.
module ddr_ctrl_arbit
  import sdram_ctrl_pkg::*;
#(
  parameter int ADDR_W = 13,
  parameter int BA_W   = 2,
  parameter int DATA_W = 16,
  parameter int CMD_W  = 4
) (
  input  logic                           sys_clk,
  input  logic                           sys_rst_n,
  input  logic                           init_end_i,
  input  logic [CMD_W+BA_W+ADDR_W-1:0]   init_bus_i,
  input  logic                           aref_req_i,
  input  logic                           aref_end_i,
  input  logic [CMD_W+BA_W+ADDR_W-1:0]   aref_bus_i,
  input  logic                           wr_req_i,
  input  logic                           wr_end_i,
  input  logic [CMD_W+BA_W+ADDR_W-1:0]   wr_bus_i,
  input  logic [DATA_W-1:0]              wr_data_i,
  input  logic                           wr_sdram_en_i,
  input  logic                           rd_req_i,
  input  logic                           rd_end_i,
  input  logic [CMD_W+BA_W+ADDR_W-1:0]   rd_bus_i,
  output logic                           aref_en_o,
  output logic                           wr_en_o,
  output logic                           rd_en_o,
  output logic [CMD_W-1:0]               sdram_cmd_o,
  output logic [BA_W-1:0]                sdram_ba_o,
  output logic [ADDR_W-1:0]              sdram_addr_o,
  output logic [DATA_W-1:0]              sdram_dq_o,
  output logic                           sdram_dq_oe_o
);

  localparam int BUS_W = CMD_W + BA_W + ADDR_W;

  arb_state_t       r_state, w_next;
  logic             r_aref_en, r_wr_en, r_rd_en;
  logic [BUS_W-1:0] w_bus;

  // Grants fire only on the ARBIT exit edge, which keeps them one cycle wide
  // and forces at least one ARBIT cycle between transactions.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state   <= IDLE;
      r_aref_en <= 1'b0;
      r_wr_en   <= 1'b0;
      r_rd_en   <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_aref_en <= (r_state == ARBIT) && (w_next == AREF);
      r_wr_en   <= (r_state == ARBIT) && (w_next == WRITE);
      r_rd_en   <= (r_state == ARBIT) && (w_next == READ);
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (init_end_i) w_next = ARBIT;
      ARBIT: begin
        if      (aref_req_i) w_next = AREF;
        else if (wr_req_i)   w_next = WRITE;
        else if (rd_req_i)   w_next = READ;
      end
      AREF:    if (aref_end_i) w_next = ARBIT;
      WRITE:   if (wr_end_i)   w_next = ARBIT;
      READ:    if (rd_end_i)   w_next = ARBIT;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_bus = init_bus_i;
    case (r_state)
      ARBIT:   w_bus = {CMD_NOP, {BA_W{1'b1}}, {ADDR_W{1'b1}}};
      AREF:    w_bus = aref_bus_i;
      WRITE:   w_bus = wr_bus_i;
      READ:    w_bus = rd_bus_i;
      default: w_bus = init_bus_i;
    endcase
  end

  assign {sdram_cmd_o, sdram_ba_o, sdram_addr_o} = w_bus;

  assign aref_en_o = r_aref_en;
  assign wr_en_o   = r_wr_en;
  assign rd_en_o   = r_rd_en;

  // Data pins are held at zero while reset is asserted.
  assign sdram_dq_o    = sys_rst_n ? wr_data_i : '0;
  assign sdram_dq_oe_o = (r_state == WRITE) && wr_sdram_en_i;

endmodule

// File: tb/tb_ddr_ctrl_arbit.sv
// Scoreboard bench for ddr_ctrl_arbit: a transaction-level owner model pushes
// expected pin/grant values each cycle; a negedge monitor pops and compares.
module tb_ddr_ctrl_arbit;
  import sdram_ctrl_pkg::*;

  localparam int BW = CMD_W + BA_W + ADDR_W;

  logic              sys_clk = 1'b0;
  logic              sys_rst_n = 1'b0;
  logic              init_end_i = 1'b0;
  logic [BW-1:0]     init_bus_i = '0, aref_bus_i = '0, wr_bus_i = '0, rd_bus_i = '0;
  logic              aref_req_i = 1'b0, aref_end_i = 1'b0;
  logic              wr_req_i = 1'b0, wr_end_i = 1'b0;
  logic              rd_req_i = 1'b0, rd_end_i = 1'b0;
  logic [DATA_W-1:0] wr_data_i = '0;
  logic              wr_sdram_en_i = 1'b0;
  logic              aref_en_o, wr_en_o, rd_en_o, sdram_dq_oe_o;
  logic [CMD_W-1:0]  sdram_cmd_o;
  logic [BA_W-1:0]   sdram_ba_o;
  logic [ADDR_W-1:0] sdram_addr_o;
  logic [DATA_W-1:0] sdram_dq_o;

  ddr_ctrl_arbit dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .init_end_i(init_end_i),
    .init_bus_i(init_bus_i), .aref_req_i(aref_req_i), .aref_end_i(aref_end_i),
    .aref_bus_i(aref_bus_i), .wr_req_i(wr_req_i), .wr_end_i(wr_end_i),
    .wr_bus_i(wr_bus_i), .wr_data_i(wr_data_i), .wr_sdram_en_i(wr_sdram_en_i),
    .rd_req_i(rd_req_i), .rd_end_i(rd_end_i), .rd_bus_i(rd_bus_i),
    .aref_en_o(aref_en_o), .wr_en_o(wr_en_o), .rd_en_o(rd_en_o),
    .sdram_cmd_o(sdram_cmd_o), .sdram_ba_o(sdram_ba_o), .sdram_addr_o(sdram_addr_o),
    .sdram_dq_o(sdram_dq_o), .sdram_dq_oe_o(sdram_dq_oe_o)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct packed {
    logic              aref_en;
    logic              wr_en;
    logic              rd_en;
    logic [BW-1:0]     bus;
    logic [DATA_W-1:0] dq;
    logic              oe;
  } obs_t;

  obs_t sb_q[$];
  int   errors = 0;
  int   checks = 0;

  // Owner model: 0 = bus free (arbitrating), 1 = aref, 2 = write, 3 = read.
  bit m_init = 0;
  int m_owner = 0;
  int m_grant = 0;

  // Engine behaviour, index 0 = aref, 1 = write, 2 = read.
  bit req[3];
  bit endp[3];
  int cnt[3];
  int dur_lo = 1, dur_hi = 5;

  sdram_bus_t rd_s, wr_s, ar_s, in_s;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    m_grant = 0;
    if (!m_init) m_init = init_end_i;
    else if (m_owner == 0) begin
      if      (aref_req_i) m_owner = 1;
      else if (wr_req_i)   m_owner = 2;
      else if (rd_req_i)   m_owner = 3;
      m_grant = m_owner;
    end else if ((m_owner == 1 && aref_end_i) || (m_owner == 2 && wr_end_i) ||
                 (m_owner == 3 && rd_end_i))
      m_owner = 0;
  endtask

  function automatic obs_t model_out();
    obs_t o;
    o.aref_en = (m_grant == 1);
    o.wr_en   = (m_grant == 2);
    o.rd_en   = (m_grant == 3);
    if (!m_init) o.bus = init_bus_i;
    else case (m_owner)
      0:       o.bus = {CMD_NOP, {BA_W{1'b1}}, {ADDR_W{1'b1}}};
      1:       o.bus = aref_bus_i;
      2:       o.bus = wr_bus_i;
      default: o.bus = rd_bus_i;
    endcase
    o.dq = wr_data_i;
    o.oe = m_init && (m_owner == 2) && wr_sdram_en_i;
    return o;
  endfunction

  task automatic apply();
    aref_req_i = req[0]; wr_req_i = req[1]; rd_req_i = req[2];
    aref_end_i = endp[0]; wr_end_i = endp[1]; rd_end_i = endp[2];
  endtask

  // One clock: update model at the edge, let engines react, push expectation.
  task automatic cyc(input bit rnd, input logic [2:0] raise);
    @(posedge sys_clk); #1;
    model_edge();
    for (int e = 0; e < 3; e++) begin
      endp[e] = 1'b0;
      if (m_grant == e + 1) begin
        req[e] = 1'b0;
        cnt[e] = $urandom_range(dur_hi, dur_lo);
      end else if (m_owner == e + 1) begin
        if (cnt[e] > 0) cnt[e]--;
        if (cnt[e] == 0) endp[e] = 1'b1;
      end else if (rnd && $urandom_range(7, 0) == 0) endp[e] = 1'b1;
      if (m_owner != e + 1 && (raise[e] || (rnd && !req[e] && $urandom_range(3, 0) == 0)))
        req[e] = 1'b1;
    end
    if (rnd) begin
      init_bus_i    = BW'($urandom);
      aref_bus_i    = BW'($urandom);
      wr_bus_i      = BW'($urandom);
      rd_bus_i      = BW'($urandom);
      wr_data_i     = DATA_W'($urandom);
      wr_sdram_en_i = 1'($urandom);
      init_end_i    = 1'($urandom);
    end
    apply();
    sb_q.push_back(model_out());
  endtask

  always @(negedge sys_clk) begin
    if (sb_q.size() > 0) begin
      obs_t e;
      e = sb_q.pop_front();
      check("sb", 64'({aref_en_o, wr_en_o, rd_en_o, sdram_cmd_o, sdram_ba_o,
                       sdram_addr_o, sdram_dq_o, sdram_dq_oe_o}), 64'(e));
    end
  end

  initial begin
    rd_s = '{cmd: CMD_READ,  ba: 2'b01, addr: 13'h0123};
    wr_s = '{cmd: CMD_WRITE, ba: 2'b10, addr: 13'h0456};
    ar_s = '{cmd: CMD_AREF,  ba: 2'b00, addr: 13'h0400};
    in_s = '{cmd: CMD_PRECHARGE, ba: 2'b00, addr: 13'h0400};
    rd_bus_i = rd_s; wr_bus_i = wr_s; aref_bus_i = ar_s; init_bus_i = in_s;
    wr_data_i = 16'hA5A5;
    for (int e = 0; e < 3; e++) begin req[e] = 0; endp[e] = 0; cnt[e] = 0; end

    #2;
    check("rst_en", 64'({aref_en_o, wr_en_o, rd_en_o}), 64'(0));
    check("rst_oe", 64'(sdram_dq_oe_o), 64'(0));
    check("rst_dq", 64'(sdram_dq_o), 64'(0));
    check("rst_bus", 64'({sdram_cmd_o, sdram_ba_o, sdram_addr_o}), 64'(in_s));
    @(negedge sys_clk); #1 sys_rst_n = 1'b1;

    cyc(0, 3'b000); cyc(0, 3'b000);
    @(negedge sys_clk); #1 init_end_i = 1'b1;
    cyc(0, 3'b000);
    cyc(0, 3'b100);
    repeat (10) cyc(0, 3'b000);

    dur_lo = 2; dur_hi = 2;
    cyc(0, 3'b111);
    repeat (20) cyc(0, 3'b000);

    dur_lo = 6; dur_hi = 6;
    cyc(0, 3'b100);
    repeat (3) cyc(0, 3'b000);
    cyc(0, 3'b001);
    repeat (14) cyc(0, 3'b000);

    @(negedge sys_clk); #1 wr_sdram_en_i = 1'b1;
    cyc(0, 3'b010);
    repeat (10) cyc(0, 3'b000);
    cyc(0, 3'b100);
    repeat (10) cyc(0, 3'b000);

    cyc(0, 3'b010);
    cyc(0, 3'b000);
    cyc(0, 3'b000);
    @(negedge sys_clk); #2 sys_rst_n = 1'b0;
    #1;
    check("arst_en", 64'({aref_en_o, wr_en_o, rd_en_o}), 64'(0));
    check("arst_oe", 64'(sdram_dq_oe_o), 64'(0));
    check("arst_dq", 64'(sdram_dq_o), 64'(0));
    check("arst_bus", 64'({sdram_cmd_o, sdram_ba_o, sdram_addr_o}), 64'(in_s));
    m_init = 0; m_owner = 0; m_grant = 0;
    for (int e = 0; e < 3; e++) begin req[e] = 0; endp[e] = 0; cnt[e] = 0; end
    init_end_i = 1'b0;
    apply();
    @(negedge sys_clk); #1 sys_rst_n = 1'b1;
    cyc(0, 3'b111);
    repeat (4) cyc(0, 3'b000);
    @(negedge sys_clk); #1 init_end_i = 1'b1;
    repeat (20) cyc(0, 3'b000);

    dur_lo = 1; dur_hi = 5;
    repeat (2000) cyc(1, 3'b000);

    @(negedge sys_clk); #1;
    check("sb_drain", 64'(sb_q.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
